// File: rtl/disp_sched.sv
// Display scheduler: measurement view, timed/blinking message preemption, scan strobe (DISP_LZB_EN: leading-zero blanking).
// Latency: inputs sampled at edge k appear on u/d/c/msg_busy after edge k+1; msg_done one cycle after the timeout tick.
// No backpressure: msg_req while a message is active is dropped; meas_load is always accepted.
module disp_sched #(
   parameter int unsigned SCAN_DIV    = 50000,
   parameter int unsigned MSG_TICKS   = 600,
   parameter int unsigned BLINK_TICKS = 150,
   parameter logic [4:0]  BLANK_CODE  = 5'd16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] meas_u,
   input  logic [4:0] meas_d,
   input  logic [4:0] meas_c,
   input  logic       meas_load,
   input  logic [4:0] msg_u,
   input  logic [4:0] msg_d,
   input  logic [4:0] msg_c,
   input  logic       msg_req,
   input  logic       msg_blink,
   output logic [4:0] u,
   output logic [4:0] d,
   output logic [4:0] c,
   output logic       scan_tick,
   output logic       msg_busy,
   output logic       msg_done
);

   localparam int DW = (SCAN_DIV    > 1) ? $clog2(SCAN_DIV)    : 1;
   localparam int HW = (MSG_TICKS   > 1) ? $clog2(MSG_TICKS)   : 1;
   localparam int PW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

   localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(MSG_TICKS - 1);
   localparam logic [PW-1:0] PHASE_LAST = PW'(BLINK_TICKS - 1);

   typedef enum logic [1:0] {
      S_MEAS,
      S_MSG_ON,
      S_MSG_OFF
   } state_t;

   state_t        state;
   logic [DW-1:0] div_cnt;
   logic [HW-1:0] hold_cnt;
   logic [PW-1:0] phase_cnt;
   logic [4:0]    mreg_u, mreg_d, mreg_c;
   logic [4:0]    mlat_u, mlat_d, mlat_c;
   logic          blink_lat;
   logic          done_pend;
   logic [4:0]    view_u, view_d, view_c;

   // Digit view implied by the current state; registered into u/d/c below.
   always_comb begin
      view_u = mreg_u;
      view_d = mreg_d;
      view_c = mreg_c;
`ifdef DISP_LZB_EN
      if (mreg_c == 5'd0) begin
         view_c = BLANK_CODE;
         if (mreg_d == 5'd0) view_d = BLANK_CODE;
      end
`endif
      case (state)
         S_MSG_ON: begin
            view_u = mlat_u;
            view_d = mlat_d;
            view_c = mlat_c;
         end
         S_MSG_OFF: begin
            view_u = BLANK_CODE;
            view_d = BLANK_CODE;
            view_c = BLANK_CODE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_MEAS;
         div_cnt   <= '0;
         hold_cnt  <= '0;
         phase_cnt <= '0;
         mreg_u    <= '0;
         mreg_d    <= '0;
         mreg_c    <= '0;
         mlat_u    <= '0;
         mlat_d    <= '0;
         mlat_c    <= '0;
         blink_lat <= 1'b0;
         done_pend <= 1'b0;
         u         <= BLANK_CODE;
         d         <= BLANK_CODE;
         c         <= BLANK_CODE;
         scan_tick <= 1'b0;
         msg_busy  <= 1'b0;
         msg_done  <= 1'b0;
      end else begin
         div_cnt   <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
         scan_tick <= (div_cnt == DIV_LAST);

         if (meas_load) begin
            mreg_u <= meas_u;
            mreg_d <= meas_d;
            mreg_c <= meas_c;
         end

         done_pend <= 1'b0;
         case (state)
            S_MEAS: begin
               if (msg_req) begin
                  mlat_u    <= msg_u;
                  mlat_d    <= msg_d;
                  mlat_c    <= msg_c;
                  blink_lat <= msg_blink;
                  hold_cnt  <= '0;
                  phase_cnt <= '0;
                  state     <= S_MSG_ON;
               end
            end
            default: begin
               // Timeout wins over a blink toggle landing on the same tick.
               if (scan_tick) begin
                  if (hold_cnt == HOLD_LAST) begin
                     state     <= S_MEAS;
                     done_pend <= 1'b1;
                  end else begin
                     hold_cnt <= hold_cnt + HW'(1);
                     if (blink_lat) begin
                        if (phase_cnt == PHASE_LAST) begin
                           phase_cnt <= '0;
                           state     <= (state == S_MSG_ON) ? S_MSG_OFF : S_MSG_ON;
                        end else begin
                           phase_cnt <= phase_cnt + PW'(1);
                        end
                     end
                  end
               end
            end
         endcase

         u        <= view_u;
         d        <= view_d;
         c        <= view_c;
         msg_busy <= (state != S_MEAS);
         msg_done <= done_pend;
      end
   end

endmodule

// File: tb/tb_disp_sched.sv
// Scoreboard bench for disp_sched: a tick-counting message model predicts every output cycle.
module tb_disp_sched;

   localparam int         SD = 4;
   localparam int         MT = 3;
   localparam int         BT = 1;
   localparam logic [4:0] BL = 5'd16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] meas_u = '0, meas_d = '0, meas_c = '0;
   logic       meas_load = 1'b0;
   logic [4:0] msg_u = '0, msg_d = '0, msg_c = '0;
   logic       msg_req = 1'b0;
   logic       msg_blink = 1'b0;
   logic [4:0] u, d, c;
   logic       scan_tick, msg_busy, msg_done;

   always #5 clk = ~clk;

   disp_sched #(
      .SCAN_DIV(SD), .MSG_TICKS(MT), .BLINK_TICKS(BT), .BLANK_CODE(BL)
   ) dut (
      .clk(clk), .rst(rst),
      .meas_u(meas_u), .meas_d(meas_d), .meas_c(meas_c), .meas_load(meas_load),
      .msg_u(msg_u), .msg_d(msg_d), .msg_c(msg_c), .msg_req(msg_req), .msg_blink(msg_blink),
      .u(u), .d(d), .c(c), .scan_tick(scan_tick), .msg_busy(msg_busy), .msg_done(msg_done)
   );

   typedef struct packed {
      logic [4:0] u, d, c;
      logic       tick, busy, done;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: edges since reset, measurement digits, and the active message
   // described as "ticks counted so far" plus a visibility flag.
   int         n = 0;
   logic [4:0] mu = '0, md = '0, mc = '0;
   logic [4:0] gu = '0, gd = '0, gc = '0;
   bit         mbusy = 0, mblink = 0, mvis = 0, mended = 0;
   int         mticks = 0;

   function automatic exp_t model_view();
      exp_t e;
      e = '0;
      if (mbusy) begin
         e.u = mvis ? gu : BL;
         e.d = mvis ? gd : BL;
         e.c = mvis ? gc : BL;
      end else begin
         e.u = mu;
         e.d = md;
         e.c = mc;
`ifdef DISP_LZB_EN
         if (mc == 5'd0) e.c = BL;
         if (mc == 5'd0 && md == 5'd0) e.d = BL;
`endif
      end
      e.busy = mbusy;
      e.done = mended;
      return e;
   endfunction

   task automatic cyc(input bit r, input bit ld, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] h, input bit rq, input logic [4:0] x,
                      input logic [4:0] y, input logic [4:0] z, input bit bl);
      exp_t e;
      bit   tk;
      @(negedge clk);
      rst = r; meas_load = ld; meas_u = a; meas_d = b; meas_c = h;
      msg_req = rq; msg_u = x; msg_d = y; msg_c = z; msg_blink = bl;
      if (r) begin
         e = '0;
         e.u = BL; e.d = BL; e.c = BL;
         n = 0; mu = '0; md = '0; mc = '0;
         mbusy = 0; mended = 0; mticks = 0; mvis = 0;
      end else begin
         e = model_view();
         e.tick = ((n + 1) % SD == 0);
         tk = (n >= SD) && (n % SD == 0);
         mended = 0;
         if (ld) begin mu = a; md = b; mc = h; end
         if (!mbusy) begin
            if (rq) begin
               mbusy = 1; mblink = bl; mvis = 1; mticks = 0;
               gu = x; gd = y; gc = z;
            end
         end else if (tk) begin
            mticks++;
            if (mticks == MT) begin
               mbusy = 0; mended = 1;
            end else if (mblink && (mticks % BT == 0)) begin
               mvis = !mvis;
            end
         end
         n++;
      end
      q.push_back(e);
   endtask

   task automatic idle(input int k);
      repeat (k) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] rdig();
      logic [4:0] v;
      v = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      return v;
   endfunction

   // Monitor: pops one expectation per cycle and compares all outputs.
   int busy_len = 0;
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("u", int'(u), int'(e.u));
            chk("d", int'(d), int'(e.d));
            chk("c", int'(c), int'(e.c));
            chk("scan_tick", int'(scan_tick), int'(e.tick));
            chk("msg_busy", int'(msg_busy), int'(e.busy));
            chk("msg_done", int'(msg_done), int'(e.done));
            if (rst) begin
               busy_len = 0;
            end else if (msg_busy) begin
               busy_len++;
            end else if (busy_len > 0) begin
               chk("msg_duration_in_range",
                   int'(busy_len >= (MT - 1) * SD + 1 && busy_len <= MT * SD), 1);
               busy_len = 0;
            end
         end
      end
   end

   initial begin
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(12);
      cyc(0, 1, 7, 3, 0, 0, 0, 0, 0, 0);
      idle(3);
      cyc(0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      // Plain message, with a second request arriving mid-message.
      cyc(0, 0, 0, 0, 0, 1, 1, 2, 3, 0);
      idle(5);
      cyc(0, 0, 0, 0, 0, 1, 4, 4, 4, 1);
      idle(10);
      // Blinking message.
      cyc(0, 0, 0, 0, 0, 1, 1, 2, 3, 1);
      idle(16);
      // Measurement load in the same cycle as the request.
      cyc(0, 1, 9, 9, 9, 1, 1, 2, 3, 0);
      idle(16);
      // Reset in the middle of a message.
      cyc(0, 0, 0, 0, 0, 1, 1, 2, 3, 1);
      idle(5);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(6);
      for (int i = 0; i < 1500; i++) begin
         cyc($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, rdig(), rdig(), rdig(),
             $urandom_range(0, 9) == 0, rdig(), rdig(), rdig(), $urandom_range(0, 1) == 1);
      end
      idle(4);
      @(posedge clk);
      #3;
      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
